// File: rtl/rat_checkpoint.sv
// rat_checkpoint: branch checkpoint store for the register alias table.
// A copy snapshots the whole RAT into a slot. A valid paste returns that
// slot one cycle later and squashes every outstanding checkpoint.
// Optional feature macro: RAT_CKPT_FREELIST_EN. When it is defined, the
// free-list head pointer is saved and restored together with each snapshot.
module rat_checkpoint #(
  parameter int ARCH_REGS = 32,
  parameter int PTAG_W    = 6,
  parameter int NUM_CKPT  = 32,
  parameter int IDX_W     = $clog2(NUM_CKPT),
  parameter int CNT_W     = $clog2(NUM_CKPT + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        copy_en,
  input  logic [IDX_W-1:0]            copy_idx,
  input  logic                        paste_en,
  input  logic [IDX_W-1:0]            paste_idx,
  input  logic [ARCH_REGS*PTAG_W-1:0] rat_map_in,
`ifdef RAT_CKPT_FREELIST_EN
  input  logic [5:0]                  fl_head_in,
  output logic [5:0]                  restore_fl_head,
`endif
  output logic                        restore_valid,
  output logic [ARCH_REGS*PTAG_W-1:0] restore_map,
  output logic [NUM_CKPT-1:0]         slot_valid,
  output logic [CNT_W-1:0]            ckpt_count,
  output logic                        full,
  output logic                        err_overwrite,
  output logic                        err_paste
);

  localparam int MAP_W = ARCH_REGS * PTAG_W;

  // Snapshot storage. It is never reset and never cleared by a paste.
  logic [MAP_W-1:0]    slot_map_q [NUM_CKPT];
  logic [NUM_CKPT-1:0] slot_valid_q, slot_valid_d;
  logic [CNT_W-1:0]    ckpt_count_q, ckpt_count_d;
  logic                full_q, full_d;
  logic                restore_valid_q, restore_valid_d;
  logic [MAP_W-1:0]    restore_map_q, restore_map_d;
  logic                err_overwrite_q, err_overwrite_d;
  logic                err_paste_q, err_paste_d;
  logic                paste_hit;
  logic                copy_go;

`ifdef RAT_CKPT_FREELIST_EN
  logic [5:0] slot_fl_q [NUM_CKPT];
  logic [5:0] restore_fl_q, restore_fl_d;
`endif

  // Next-state logic: a paste takes priority, and a copy issued in the
  // same cycle is dropped without raising any error.
  always_comb begin
    paste_hit       = paste_en && slot_valid_q[paste_idx];
    copy_go         = copy_en && !paste_en;
    slot_valid_d    = slot_valid_q;
    restore_valid_d = paste_hit;
    restore_map_d   = restore_map_q;
    err_paste_d     = paste_en && !paste_hit;
    err_overwrite_d = err_overwrite_q | (copy_go && slot_valid_q[copy_idx]);
`ifdef RAT_CKPT_FREELIST_EN
    restore_fl_d    = restore_fl_q;
`endif
    if (paste_hit) begin
      // The restore squashes every younger branch, so all slots are freed.
      slot_valid_d  = '0;
      restore_map_d = slot_map_q[paste_idx];
`ifdef RAT_CKPT_FREELIST_EN
      restore_fl_d  = slot_fl_q[paste_idx];
`endif
    end else if (copy_go) begin
      slot_valid_d[copy_idx] = 1'b1;
    end
  end

  // Occupancy count and full flag, derived from next-state valid bits so the
  // registered values agree with slot_valid in every cycle.
  always_comb begin
    ckpt_count_d = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      ckpt_count_d = ckpt_count_d + CNT_W'(slot_valid_d[i]);
    end
    full_d = (ckpt_count_d == CNT_W'(NUM_CKPT));
  end

  // Control and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid_q    <= '0;
      ckpt_count_q    <= '0;
      full_q          <= 1'b0;
      restore_valid_q <= 1'b0;
      restore_map_q   <= '0;
      err_overwrite_q <= 1'b0;
      err_paste_q     <= 1'b0;
`ifdef RAT_CKPT_FREELIST_EN
      restore_fl_q    <= '0;
`endif
    end else begin
      slot_valid_q    <= slot_valid_d;
      ckpt_count_q    <= ckpt_count_d;
      full_q          <= full_d;
      restore_valid_q <= restore_valid_d;
      restore_map_q   <= restore_map_d;
      err_overwrite_q <= err_overwrite_d;
      err_paste_q     <= err_paste_d;
`ifdef RAT_CKPT_FREELIST_EN
      restore_fl_q    <= restore_fl_d;
`endif
    end
  end

  // Snapshot write port. The storage has no reset because its contents
  // are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (copy_go) begin
      slot_map_q[copy_idx] <= rat_map_in;
`ifdef RAT_CKPT_FREELIST_EN
      slot_fl_q[copy_idx]  <= fl_head_in;
`endif
    end
  end

  assign slot_valid    = slot_valid_q;
  assign ckpt_count    = ckpt_count_q;
  assign full          = full_q;
  assign restore_valid = restore_valid_q;
  assign restore_map   = restore_map_q;
  assign err_overwrite = err_overwrite_q;
  assign err_paste     = err_paste_q;
`ifdef RAT_CKPT_FREELIST_EN
  assign restore_fl_head = restore_fl_q;
`endif

endmodule

// File: tb/tb_rat_checkpoint.sv
// Testbench for rat_checkpoint: directed scenarios followed by random traffic,
// all compared against a slot-array reference model.
module tb_rat_checkpoint;

  localparam int MW = 32 * 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          copy_en = 1'b0;
  logic [4:0]    copy_idx = '0;
  logic          paste_en = 1'b0;
  logic [4:0]    paste_idx = '0;
  logic [MW-1:0] rat_map_in = '0;
  logic          restore_valid;
  logic [MW-1:0] restore_map;
  logic [31:0]   slot_valid;
  logic [5:0]    ckpt_count;
  logic          full;
  logic          err_overwrite;
  logic          err_paste;
`ifdef RAT_CKPT_FREELIST_EN
  logic [5:0]    fl_head_in = '0;
  logic [5:0]    restore_fl_head;
  logic [5:0]    m_fl [32];
  logic [5:0]    exp_fl;
`endif

  // Reference model state
  logic [MW-1:0] m_slot [32];
  logic [31:0]   m_valid;
  logic          exp_rv, exp_errp, exp_errow;
  logic [MW-1:0] exp_map;

  int errors = 0;
  int checks = 0;

  rat_checkpoint dut (
    .clk           (clk),
    .rst           (rst),
    .copy_en       (copy_en),
    .copy_idx      (copy_idx),
    .paste_en      (paste_en),
    .paste_idx     (paste_idx),
    .rat_map_in    (rat_map_in),
`ifdef RAT_CKPT_FREELIST_EN
    .fl_head_in    (fl_head_in),
    .restore_fl_head(restore_fl_head),
`endif
    .restore_valid (restore_valid),
    .restore_map   (restore_map),
    .slot_valid    (slot_valid),
    .ckpt_count    (ckpt_count),
    .full          (full),
    .err_overwrite (err_overwrite),
    .err_paste     (err_paste)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] rand_map();
    logic [MW-1:0] m;
    for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [MW-1:0] fill_map(input logic [5:0] v);
    logic [MW-1:0] m;
    for (int r = 0; r < 32; r++) m[r*6 +: 6] = v;
    return m;
  endfunction

  task automatic model_reset();
    m_valid   = '0;
    exp_rv    = 1'b0;
    exp_errp  = 1'b0;
    exp_errow = 1'b0;
    exp_map   = '0;
`ifdef RAT_CKPT_FREELIST_EN
    exp_fl    = '0;
`endif
  endtask

  // Behaviour of one rising edge expressed as the slot rules: paste wins,
  // a successful paste empties the table, a failed one only flags.
  task automatic model_edge();
    exp_rv   = 1'b0;
    exp_errp = 1'b0;
    if (paste_en) begin
      if (m_valid[paste_idx]) begin
        exp_rv  = 1'b1;
        exp_map = m_slot[paste_idx];
`ifdef RAT_CKPT_FREELIST_EN
        exp_fl  = m_fl[paste_idx];
`endif
        m_valid = '0;
      end else begin
        exp_errp = 1'b1;
      end
    end else if (copy_en) begin
      if (m_valid[copy_idx]) exp_errow = 1'b1;
      m_slot[copy_idx]  = rat_map_in;
`ifdef RAT_CKPT_FREELIST_EN
      m_fl[copy_idx]    = fl_head_in;
`endif
      m_valid[copy_idx] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    int cnt;
    cnt = $countones(m_valid);
    chk({tag, ".slot_valid"},    MW'(slot_valid),    MW'(m_valid));
    chk({tag, ".ckpt_count"},    MW'(ckpt_count),    MW'(cnt));
    chk({tag, ".full"},          MW'(full),          MW'(cnt == 32));
    chk({tag, ".restore_valid"}, MW'(restore_valid), MW'(exp_rv));
    chk({tag, ".restore_map"},   restore_map,        exp_map);
    chk({tag, ".err_overwrite"}, MW'(err_overwrite), MW'(exp_errow));
    chk({tag, ".err_paste"},     MW'(err_paste),     MW'(exp_errp));
`ifdef RAT_CKPT_FREELIST_EN
    chk({tag, ".restore_fl"},    MW'(restore_fl_head), MW'(exp_fl));
`endif
  endtask

  task automatic drive(input logic c, input logic [4:0] ci, input logic p,
                       input logic [4:0] pi, input logic [MW-1:0] map);
    copy_en    = c;
    copy_idx   = ci;
    paste_en   = p;
    paste_idx  = pi;
    rat_map_in = map;
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    check_all(tag);
    drive(1'b0, 5'd0, 1'b0, 5'd0, '0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    cyc({tag, ".held"});
    rst = 1'b1;
  endtask

  initial begin
    logic [MW-1:0] map_a;
    model_reset();

    // Power-on reset
    #2;
    check_all("por");
    cyc("por_edge");
    rst = 1'b1;

    // Copy slot 3 with all-0x05, then paste it back
    drive(1'b1, 5'd3, 1'b0, 5'd0, fill_map(6'h05));
    cyc("copy3");
    drive(1'b0, 5'd0, 1'b1, 5'd3, '0);
    cyc("paste3");
    chk("paste3.map_all05", restore_map, fill_map(6'h05));
    cyc("paste3_after");

    // Fill every slot, then overwrite slot 7
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 1'b0, 5'd0, rand_map());
`ifdef RAT_CKPT_FREELIST_EN
      fl_head_in = 6'($urandom);
`endif
      cyc("fill");
    end
    chk("fill.full", MW'(full), MW'(1));
    chk("fill.count32", MW'(ckpt_count), MW'(32));
    drive(1'b1, 5'd7, 1'b0, 5'd0, rand_map());
    cyc("overwrite7");
    chk("overwrite7.err", MW'(err_overwrite), MW'(1));
    drive(1'b0, 5'd0, 1'b1, 5'd7, '0);
    cyc("paste7");
    cyc("sticky");

    do_reset("rst1");

    // Copy and paste of the same slot in one cycle: paste wins
    map_a = rand_map();
    drive(1'b1, 5'd4, 1'b0, 5'd0, map_a);
    cyc("copy4");
    drive(1'b1, 5'd4, 1'b1, 5'd4, rand_map());
    cyc("copy_paste4");
    chk("copy_paste4.mapA", restore_map, map_a);
    cyc("hold_map");

    // Paste of an empty slot
    drive(1'b0, 5'd0, 1'b1, 5'd9, '0);
    cyc("paste9_invalid");
    chk("paste9.err_paste", MW'(err_paste), MW'(1));
    cyc("paste9_after");

    // Back-to-back pastes: the second sees the table emptied by the first
    drive(1'b1, 5'd1, 1'b0, 5'd0, rand_map());
    cyc("copy1");
    drive(1'b1, 5'd2, 1'b0, 5'd0, rand_map());
    cyc("copy2");
    drive(1'b0, 5'd0, 1'b1, 5'd1, '0);
    cyc("b2b_paste1");
    drive(1'b0, 5'd0, 1'b1, 5'd2, '0);
    cyc("b2b_paste2");

    // Reset arriving while a restore pulse is outstanding
    drive(1'b1, 5'd2, 1'b0, 5'd0, rand_map());
    cyc("copy2b");
    drive(1'b0, 5'd0, 1'b1, 5'd2, '0);
    cyc("paste2_pending");
    drive(1'b0, 5'd0, 1'b1, 5'd2, '0);
    do_reset("rst_cancel");
    chk("rst_cancel.rv", MW'(restore_valid), MW'(0));

`ifdef RAT_CKPT_FREELIST_EN
    // Free-list head travels with the snapshot
    fl_head_in = 6'h2A;
    drive(1'b1, 5'd1, 1'b0, 5'd0, rand_map());
    cyc("fl_copy1");
    drive(1'b0, 5'd0, 1'b1, 5'd1, '0);
    cyc("fl_paste1");
    chk("fl_paste1.head2A", MW'(restore_fl_head), MW'(6'h2A));
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 99) < 60), 5'($urandom), ($urandom_range(0, 99) < 12),
            5'($urandom), rand_map());
`ifdef RAT_CKPT_FREELIST_EN
      fl_head_in = 6'($urandom);
`endif
      if (n == 300) do_reset("rst_rand");
      else cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rat_checkpoint.md
RAT_CHECKPOINT -- requirements
Module: rat_checkpoint

Interface
REQ-001 Parameter ARCH_REGS, 32: architectural register count.
REQ-002 Parameter PTAG_W, 6: physical tag width.
REQ-003 Parameter NUM_CKPT, 32: checkpoint slots; slot index width 5.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 copy_en  input  1  snapshot request, driven by branch buffer Copy_RAT.
REQ-007 copy_idx  input  5  slot to write, driven by branch buffer tail_num.
REQ-008 paste_en  input  1  restore request, driven by branch buffer Paste_RAT.
REQ-009 paste_idx  input  5  slot to restore, driven by branch buffer head_num.
REQ-010 rat_map_in  input  ARCH_REGS*PTAG_W  current RAT mappings; reg r occupies bits [r*PTAG_W +: PTAG_W].
REQ-011 restore_valid  output  1  one-cycle pulse; restore_map is valid.
REQ-012 restore_map  output  ARCH_REGS*PTAG_W  restored mappings, same packing as rat_map_in.
REQ-013 slot_valid  output  NUM_CKPT  per-slot occupancy bitmap.
REQ-014 ckpt_count  output  6  number of set slot_valid bits, 0..32.
REQ-015 full  output  1  high when ckpt_count == 32.
REQ-016 err_overwrite  output  1  sticky; copy hit an already-valid slot.
REQ-017 err_paste  output  1  one-cycle pulse; paste hit an invalid slot.

Function
REQ-018 Copy: edge with copy_en=1 and paste_en=0 SHALL store rat_map_in into slot copy_idx and set slot_valid[copy_idx].
REQ-019 Copy into a valid slot SHALL still overwrite it and set err_overwrite.
REQ-020 Paste: edge with paste_en=1 and slot_valid[paste_idx]=1 SHALL drive restore_map = stored slot on the next cycle with restore_valid=1 for exactly one cycle (latency 1).
REQ-021 A valid paste SHALL clear all slot_valid bits at that same edge, because all younger branches are squashed.
REQ-022 Paste to an invalid slot SHALL NOT pulse restore_valid, SHALL leave slot_valid unchanged, and SHALL pulse err_paste in the next cycle.
REQ-023 copy_en and paste_en in the same cycle: paste wins, copy is dropped, and no error is flagged.
REQ-024 Back-to-back pastes on consecutive edges SHALL each be evaluated against the slot_valid produced by the previous edge.
REQ-025 ckpt_count and full SHALL be registered and consistent with slot_valid in the same cycle.
REQ-026 restore_map SHALL hold its last value when restore_valid=0.
REQ-027 copy_idx wraps naturally at 5 bits; no pointer is kept internally.
REQ-028 Slot storage SHALL NOT be cleared by paste; only slot_valid is cleared.

Reset
REQ-029 rst=0 SHALL asynchronously force: slot_valid=0, ckpt_count=0, full=0, restore_valid=0, restore_map=0, err_overwrite=0, err_paste=0.
REQ-030 Slot storage contents are don't-care after reset.
REQ-031 Reset asserted during a pending restore SHALL cancel the pulse.
REQ-032 The first edge after rst deasserts SHALL accept copy/paste.

Configuration
REQ-033 Macro RAT_CKPT_FREELIST_EN: when defined, adds input fl_head_in [5:0] and output restore_fl_head [5:0].
REQ-034 With RAT_CKPT_FREELIST_EN, fl_head_in is stored alongside each snapshot and restored with the same timing as restore_map; restore_fl_head resets to 0.
REQ-035 Without RAT_CKPT_FREELIST_EN, these ports and storage are absent; all other behaviour is identical.

Verification
REQ-036 Copy slot 3 with map all-0x05, then paste slot 3 -> next cycle restore_valid=1, restore_map all-0x05; slot_valid=0.
REQ-037 Copy slots 0..31 -> full=1, ckpt_count=32; copy slot 7 again -> err_overwrite=1.
REQ-038 Copy slot 4 and paste slot 4 (valid, map A) in the same cycle -> restore_map=A, slot_valid=0, no error.
REQ-039 Paste slot 9 with slot_valid=0 -> err_paste pulse, no restore_valid, ckpt_count unchanged.
REQ-040 Paste slot 2 issued, then rst=0 asserted before the next edge -> restore_valid stays 0 and all outputs are at reset values.
REQ-041 With RAT_CKPT_FREELIST_EN: copy slot 1 with fl_head_in=0x2A, paste slot 1 -> restore_fl_head=0x2A alongside restore_valid.
